// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, FSM state type and word-index helper for mem_stage
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int DEST_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Byte address to word index relative to the mapped base; callers keep
    // only the low clog2(DEPTH) bits, which gives the wrap-around.
    function automatic logic [DATA_W-1:0] word_index(
        input logic [DATA_W-1:0] addr,
        input logic [DATA_W-1:0] base
    );
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EXE/MEM inputs, freeze and MEM/WB outputs of the memory stage
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] ST_value;
    logic [DEST_W-1:0] dest;
    logic              MEM_R_en;
    logic              MEM_W_en;
    logic              WB_en;

    logic              freeze;
    logic [DATA_W-1:0] WB_ALU_result;
    logic [DATA_W-1:0] WB_mem_data;
    logic [DEST_W-1:0] WB_dest;
    logic              WB_MEM_R_en;
    logic              WB_WB_en;

    modport master (
        output ALU_result, ST_value, dest, MEM_R_en, MEM_W_en, WB_en,
        input  freeze, WB_ALU_result, WB_mem_data, WB_dest, WB_MEM_R_en, WB_WB_en
    );

    modport slave (
        input  ALU_result, ST_value, dest, MEM_R_en, MEM_W_en, WB_en,
        output freeze, WB_ALU_result, WB_mem_data, WB_dest, WB_MEM_R_en, WB_WB_en
    );

endinterface

// File: rtl/mem_stage_data_mem_array.sv
// rtl/mem_stage_data_mem_array.sv - word storage with synchronous write and asynchronous read
module data_mem_array
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store commits on the clock edge; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage with wait-state FSM, freeze and MEM/WB register (optional MEM_STAGE_STALL_CNT_EN)
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BASE   = 1024
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEM_STAGE_STALL_CNT_EN
    output logic [DATA_W-1:0] stall_cycles,
`endif
    mem_stage_if.slave        bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               access;
    logic               freeze_raw;
    logic               we;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  rdata;

    assign access = bus.MEM_R_en | bus.MEM_W_en;

    // Next state, wait counter and stall request.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        freeze_raw = 1'b0;
        case (state)
            IDLE: begin
                if (access && (WAIT_CYCLES > 0)) begin
                    freeze_raw = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    freeze_raw = 1'b1;
                    cnt_next   = cnt - CNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset forces freeze low and blocks any store still in flight.
    assign bus.freeze = freeze_raw & rst;
    assign we         = bus.MEM_W_en & rst & ~freeze_raw;
    assign idx        = IDX_W'(word_index(bus.ALU_result, DATA_W'(ADDR_BASE)));

    data_mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (idx),
        .wdata (bus.ST_value),
        .rdata (rdata)
    );

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // MEM/WB register: capture on completion, insert a bubble while frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.WB_ALU_result <= '0;
            bus.WB_mem_data   <= '0;
            bus.WB_dest       <= '0;
            bus.WB_MEM_R_en   <= 1'b0;
            bus.WB_WB_en      <= 1'b0;
        end else if (!freeze_raw) begin
            bus.WB_ALU_result <= bus.ALU_result;
            bus.WB_mem_data   <= (bus.MEM_R_en && !bus.MEM_W_en) ? rdata : '0;
            bus.WB_dest       <= bus.dest;
            bus.WB_MEM_R_en   <= bus.MEM_R_en;
            bus.WB_WB_en      <= bus.WB_en;
        end else begin
            bus.WB_MEM_R_en   <= 1'b0;
            bus.WB_WB_en      <= 1'b0;
        end
    end

`ifdef MEM_STAGE_STALL_CNT_EN
    // Saturating count of frozen cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (freeze_raw && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + DATA_W'(1);
        end
    end
`endif

endmodule
